// File: rtl/muldiv_unit_if.sv
// EX-stage <-> multiply/divide unit handshake: issue fields in, status and result out.
// The master is the pipeline EX stage and the slave is muldiv_unit.
interface muldiv_unit_if #(
  parameter int XLEN       = 32,
  parameter int RF_ADDRESS = 5
);
  logic                  start;
  logic                  flush;
  logic [2:0]            funct3;
  logic [XLEN-1:0]       op_a;
  logic [XLEN-1:0]       op_b;
  logic [RF_ADDRESS-1:0] rd_in;
  logic                  busy;
  logic                  done;
  logic                  stall_req;
  logic [XLEN-1:0]       result;
  logic [RF_ADDRESS-1:0] rd_out;

  modport master (
    output start, flush, funct3, op_a, op_b, rd_in,
    input  busy, done, stall_req, result, rd_out
  );

  modport slave (
    input  start, flush, funct3, op_a, op_b, rd_in,
    output busy, done, stall_req, result, rd_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M mul/div: done K+1 cycles after start (1 for div-by-zero/overflow),
// K = XLEN/BITS_PER_CYCLE; holds the pipeline via stall_req, flush aborts, start while busy is ignored.
module muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int RF_ADDRESS     = 5
) (
  input  logic        clk,
  input  logic        reset,
  muldiv_unit_if.slave io
);
  localparam int K  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(K);
  localparam int W  = XLEN + BITS_PER_CYCLE;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]       opnd_q, opnd_d;
  logic [2:0]            f3_q, f3_d;
  logic                  neg_q, neg_d, neg_r_q, neg_r_d;
  logic [RF_ADDRESS-1:0] rd_q, rd_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic [XLEN-1:0]       result_q, result_d;
  logic [RF_ADDRESS-1:0] rd_out_q, rd_out_d;

  logic                  a_signed, b_signed, sa, sb, is_div, b_zero, ovf, special;
  logic [XLEN-1:0]       a_mag, b_mag, spec_res;

  always_comb begin
    is_div   = io.funct3[2];
    a_signed = io.funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
    b_signed = io.funct3 inside {3'b001, 3'b100, 3'b110};
    sa       = a_signed & io.op_a[XLEN-1];
    sb       = b_signed & io.op_b[XLEN-1];
    a_mag    = sa ? -io.op_a : io.op_a;
    b_mag    = sb ? -io.op_b : io.op_b;
    b_zero   = (io.op_b == '0);
    ovf      = b_signed & is_div & (io.op_a == {1'b1, {(XLEN-1){1'b0}}}) & (io.op_b == '1);
    special  = is_div & (b_zero | ovf);
    if (b_zero) spec_res = io.funct3[1] ? io.op_a : '1;
    else        spec_res = io.funct3[1] ? '0 : io.op_a;
  end

  // acc holds {partial product, multiplier} for MUL* and {remainder, dividend/quotient} for DIV*
  logic [W-1:0]          pp, psum;
  logic [XLEN:0]         r_ext;
  logic [XLEN-1:0]       rem_v, quo_v, fin;
  logic [2*XLEN-1:0]     step, prod;

  always_comb begin
    pp    = W'(opnd_q) * W'(acc_q[BITS_PER_CYCLE-1:0]);
    psum  = W'(acc_q[2*XLEN-1:XLEN]) + pp;
    rem_v = acc_q[2*XLEN-1:XLEN];
    quo_v = acc_q[XLEN-1:0];
    r_ext = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      r_ext = {rem_v, quo_v[XLEN-1]};
      quo_v = {quo_v[XLEN-2:0], 1'b0};
      if (r_ext >= {1'b0, opnd_q}) begin
        r_ext    = r_ext - {1'b0, opnd_q};
        quo_v[0] = 1'b1;
      end
      rem_v = r_ext[XLEN-1:0];
    end
    step = f3_q[2] ? {rem_v, quo_v} : {psum, acc_q[XLEN-1:BITS_PER_CYCLE]};
    prod = neg_q ? -step : step;
    if (f3_q[2]) begin
      if (f3_q[1]) fin = neg_r_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
      else         fin = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
    end else begin
      fin = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    neg_r_d  = neg_r_q;
    rd_d     = rd_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    case (state_q)
      IDLE: begin
        if (io.start && !io.flush) begin
          if (special) begin
            state_d  = DONE;
            result_d = spec_res;
            rd_out_d = io.rd_in;
          end else begin
            state_d = CALC;
            cnt_d   = '0;
            f3_d    = io.funct3;
            rd_d    = io.rd_in;
            neg_d   = sa ^ sb;
            neg_r_d = sa;
            opnd_d  = is_div ? b_mag : a_mag;
            acc_d   = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
          end
        end
      end
      CALC: begin
        if (io.flush) begin
          state_d = IDLE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d  = DONE;
            result_d = fin;
            rd_out_d = rd_q;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      rd_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      neg_r_q  <= neg_r_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  // A flushed op must not retire, even in its DONE cycle
  assign io.done      = done_q & ~io.flush;
  assign io.busy      = busy_q;
  assign io.stall_req = ((state_q == IDLE) & io.start & ~io.flush) | (state_q == CALC);
  assign io.result    = result_q;
  assign io.rd_out    = rd_out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboarded bench: u0 is XLEN=32/BPC=1, u1 is XLEN=32/BPC=4; expectations are hand-computed.
module tb_muldiv_unit;
  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   stall_hi;
  logic [31:0] last_exp0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  muldiv_unit_if #(.XLEN(32), .RF_ADDRESS(5)) io0();
  muldiv_unit_if #(.XLEN(32), .RF_ADDRESS(5)) io1();

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1), .RF_ADDRESS(5)) u0 (.clk(clk), .reset(rst0), .io(io0));
  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4), .RF_ADDRESS(5)) u1 (.clk(clk), .reset(rst1), .io(io1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst0 && io0.done) begin
      if (q0.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL u0_unexpected_done: got done with result %0h, required no done", io0.result);
      end else begin
        e0 = q0.pop_front();
        chk("u0_result", 64'(io0.result), 64'(e0.res));
        chk("u0_rd", 64'(io0.rd_out), 64'(e0.rd));
        chk("u0_done_cycle", 64'(cyc), 64'(e0.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst1 && io1.done) begin
      if (q1.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL u1_unexpected_done: got done with result %0h, required no done", io1.result);
      end else begin
        e1 = q1.pop_front();
        chk("u1_result", 64'(io1.result), 64'(e1.res));
        chk("u1_rd", 64'(io1.rd_out), 64'(e1.rd));
        chk("u1_done_cycle", 64'(cyc), 64'(e1.cyc));
      end
    end
  end

  task automatic wait0();
    for (int i = 0; i < 100 && q0.size() != 0; i++) @(negedge clk);
    if (q0.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL u0_timeout: %0d results outstanding, required 0", q0.size());
      q0.delete();
    end
  endtask

  task automatic wait1();
    for (int i = 0; i < 100 && q1.size() != 0; i++) @(negedge clk);
    if (q1.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL u1_timeout: %0d results outstanding, required 0", q1.size());
      q1.delete();
    end
  endtask

  task automatic issue0(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] res, input int lat);
    @(negedge clk);
    io0.funct3 = f3; io0.op_a = a; io0.op_b = b; io0.rd_in = rd; io0.start = 1'b1;
    q0.push_back('{res, rd, cyc + lat});
    last_exp0 = res;
    @(negedge clk);
    io0.start = 1'b0;
    wait0();
  endtask

  task automatic issue1(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] res, input int lat);
    @(negedge clk);
    io1.funct3 = f3; io1.op_a = a; io1.op_b = b; io1.rd_in = rd; io1.start = 1'b1;
    q1.push_back('{res, rd, cyc + lat});
    @(negedge clk);
    io1.start = 1'b0;
    wait1();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    io0.start = 1'b0; io0.flush = 1'b0; io0.funct3 = 3'b0; io0.op_a = '0; io0.op_b = '0; io0.rd_in = '0;
    io1.start = 1'b0; io1.flush = 1'b0; io1.funct3 = 3'b0; io1.op_a = '0; io1.op_b = '0; io1.rd_in = '0;
    last_exp0 = '0;
    repeat (3) @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    chk("reset_busy", 64'(io0.busy), 64'd0);
    chk("reset_done", 64'(io0.done), 64'd0);
    chk("reset_stall", 64'(io0.stall_req), 64'd0);
    chk("reset_result", 64'(io0.result), 64'd0);
    chk("reset_rd_out", 64'(io0.rd_out), 64'd0);
    chk("reset_u1_busy", 64'(io1.busy), 64'd0);

    // MUL with stall window: stall high in the start cycle and all 32 CALC cycles, low in DONE
    @(negedge clk);
    io0.funct3 = F_MUL; io0.op_a = 32'd7; io0.op_b = 32'hFFFF_FFFD; io0.rd_in = 5'd1; io0.start = 1'b1;
    q0.push_back('{32'hFFFF_FFEB, 5'd1, cyc + 33});
    last_exp0 = 32'hFFFF_FFEB;
    #1 stall_hi = int'(io0.stall_req);
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      io0.start = 1'b0;
      stall_hi += int'(io0.stall_req);
    end
    chk("stall_cycles_0_to_32", 64'(stall_hi), 64'd33);
    @(negedge clk);
    chk("stall_in_done", 64'(io0.stall_req), 64'd0);
    wait0();

    issue0(F_MULH,   32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 33);
    issue0(F_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd3,  32'hFFFF_FFFF, 33);
    issue0(F_DIV,    32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD, 33);
    issue0(F_REM,    32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFF, 33);
    issue0(F_DIV,    32'd7,         32'hFFFF_FFFE, 5'd6,  32'hFFFF_FFFD, 33);
    issue0(F_REM,    32'd7,         32'hFFFF_FFFE, 5'd7,  32'd1,         33);
    issue0(F_DIVU,   32'd100,       32'd7,         5'd8,  32'd14,        33);
    issue0(F_REMU,   32'd100,       32'd7,         5'd9,  32'd2,         33);
    issue0(F_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0,         33);
    issue0(F_DIVU,   32'd7,         32'd0,         5'd11, 32'hFFFF_FFFF, 1);
    issue0(F_REMU,   32'd7,         32'd0,         5'd12, 32'd7,         1);
    issue0(F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
    issue0(F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,         1);
    issue0(F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 32'hFFFF_FFFE, 33);

    // Flush at CALC iteration 10, then a fresh op the next cycle
    @(negedge clk);
    io0.funct3 = F_MUL; io0.op_a = 32'd5; io0.op_b = 32'd6; io0.rd_in = 5'd20; io0.start = 1'b1;
    @(negedge clk);
    io0.start = 1'b0;
    repeat (10) @(negedge clk);
    io0.flush = 1'b1;
    @(negedge clk);
    io0.flush = 1'b0;
    chk("flush_busy", 64'(io0.busy), 64'd0);
    chk("flush_result_kept", 64'(io0.result), 64'(last_exp0));
    chk("flush_rd_kept", 64'(io0.rd_out), 64'd15);
    io0.funct3 = F_DIVU; io0.op_a = 32'd100; io0.op_b = 32'd7; io0.rd_in = 5'd21; io0.start = 1'b1;
    q0.push_back('{32'd14, 5'd21, cyc + 33});
    @(negedge clk);
    io0.start = 1'b0;
    wait0();

    // BPC=4: start pulsed while busy must not disturb the op in flight
    @(negedge clk);
    io1.funct3 = F_DIV; io1.op_a = 32'd1000; io1.op_b = 32'd3; io1.rd_in = 5'd3; io1.start = 1'b1;
    q1.push_back('{32'd333, 5'd3, cyc + 9});
    @(negedge clk);
    io1.start = 1'b0;
    repeat (3) @(negedge clk);
    io1.funct3 = F_MUL; io1.op_a = 32'd2; io1.op_b = 32'd2; io1.rd_in = 5'd9; io1.start = 1'b1;
    @(negedge clk);
    io1.start = 1'b0;
    wait1();
    repeat (12) @(negedge clk);
    chk("u1_idle_after_ignored_start", 64'(io1.busy), 64'd0);

    // BPC=4: reset in mid-CALC clears everything and the op never completes
    @(negedge clk);
    io1.funct3 = F_MUL; io1.op_a = 32'd3; io1.op_b = 32'd4; io1.rd_in = 5'd7; io1.start = 1'b1;
    @(negedge clk);
    io1.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("u1_busy_mid_calc", 64'(io1.busy), 64'd1);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    chk("u1_reset_busy", 64'(io1.busy), 64'd0);
    chk("u1_reset_result", 64'(io1.result), 64'd0);
    chk("u1_reset_rd_out", 64'(io1.rd_out), 64'd0);
    repeat (12) @(negedge clk);

    issue1(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 9);
    issue1(F_REMU,  32'd1000,      32'd3,         5'd5, 32'd1,         9);
    issue1(F_MUL,   32'd7,         32'hFFFF_FFFD, 5'd6, 32'hFFFF_FFEB, 9);

    repeat (5) @(negedge clk);
    chk("u0_queue_drained", 64'(q0.size()), 64'd0);
    chk("u1_queue_drained", 64'(q1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
